alu_muldiv_sequencer: RTL
=========================

// Module: alu_muldiv_sequencer
// PURPOSE
//  Multi-cycle 16x16 unsigned multiply and 16/16 unsigned divide controller.
//  Drives the shared 16-bit ALU one add (multiply) or one subtract (divide)
//  per cycle for 16 iterations, with no multiplier/divider array of its own.
//  Sits beside the ALU in the CPU execute stage; the decoder starts it, and it
//  owns the ALU A/B/op inputs whenever busy is high.
// PARAMETERS
//  WIDTH  16  operand width; the iteration count equals WIDTH (only 16 supported)
// PORTS
//  clk           in   1   single clock; all state updates on the rising edge
//  rst_n         in   1   asynchronous, active-low reset
//  start         in   1   begin an operation; sampled only in IDLE
//  mode          in   1   0 = multiply, 1 = divide; sampled with start
//  opa           in   16  multiplicand / dividend; sampled with start
//  opb           in   16  multiplier / divisor; sampled with start
//  busy          out  1   high in RUN
//  done          out  1   one-cycle pulse in the DONE state
//  result_lo     out  16  product[15:0] / quotient
//  result_hi     out  16  product[31:16] / remainder
//  div_by_zero   out  1   set at DONE of a divide with opb==0; cleared on next start
//  alu_a         out  16  ALU A operand
//  alu_b         out  16  ALU B operand
//  alu_op        out  5   ALU opcode: ADD=5'b00001, SUB=5'b00011
//  alu_q         in   16  ALU result
//  alu_carry     in   1   ALU carry out (SUB: 1 = no borrow, A>=B)
// BEHAVIOUR
//  Reset: state=IDLE, count=0, every output 0, alu_op=ADD.
//  FSM: IDLE -start-> RUN (count=0); RUN -count==15-> DONE; DONE -> IDLE.
//   Divide with opb==0: IDLE -start-> DONE directly; lo=16'hFFFF, hi=opa,
//   div_by_zero=1.
//  Latency: start is sampled at edge 0; done is high in cycle 17 (cycle 1 for
//   divide-by-zero). start in RUN/DONE is ignored, with no queueing.
//  Multiply (hi=acc=0, lo=opb, mcand=opa): alu_a=hi, alu_b=lo[0]?mcand:0, ADD;
//   the edge loads {hi,lo} <= {alu_carry,alu_q,lo[15:1]}.
//  Divide (hi=rem=0, lo=quot=opa, dvsr=opb): alu_a={hi[14:0],lo[15]},
//   alu_b=dvsr, SUB; take=hi[15]|alu_carry; hi<=take?alu_q:alu_a;
//   lo<={lo[14:0],take}.
//  In IDLE/DONE the block drives alu_a=alu_b=0 and alu_op=ADD.
//  Results are the working registers. They change during RUN and hold from
//   DONE until the next accepted start.
//  Reset mid-RUN aborts at once: no done, results and flags are 0.
// CONFIGURATION
//  MULDIV_ABORT_EN defined:
//   - Adds input port abort (1 bit).
//   - abort high in RUN forces IDLE at the next edge: busy drops, no done,
//     results are undefined-but-stable, div_by_zero=0.
//   - abort outside RUN is ignored. abort and start together in IDLE: start wins.
//  MULDIV_ABORT_EN undefined: no abort port; RUN always runs to completion.
// TESTING
//  1 mul 0x1234*0x5678 -> {hi,lo}=0x0626_0060, done exactly 17 cycles after start
//  2 mul 0xFFFF*0xFFFF -> {hi,lo}=0xFFFE_0001; 0x0000*0xBEEF -> 0
//  3 div 1000/7 -> lo=0x008E, hi=0x0006; div 0xFFFF/0x0001 -> lo=0xFFFF, hi=0
//  4 div 0x1234/0 -> lo=0xFFFF, hi=0x1234, div_by_zero=1, done in cycle 1
//  5 start pulsed at RUN cycle 8 -> ignored, result of the first op unchanged;
//    rst_n low at cycle 5 -> all outputs 0, no done
//  6 (MULDIV_ABORT_EN) abort at RUN cycle 5 -> busy=0 next cycle, no done pulse

Source files
------------

// File: rtl/alu_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_muldiv_sequencer
// Brief    : Multi-cycle 16x16 unsigned multiply / 16/16 unsigned divide that
//            borrows the shared execute-stage ALU, one add or subtract per cycle.
//            Optional abort port enabled by defining MULDIV_ABORT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module alu_muldiv_sequencer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
`ifdef MULDIV_ABORT_EN
    input  logic             abort_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_lo_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic             div_by_zero_o,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [4:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_q_i,
    input  logic             alu_carry_i
);

    localparam int            CW        = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [4:0] ALU_ADD = 5'b00001;
    localparam logic [4:0] ALU_SUB = 5'b00011;

    logic [1:0]       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic             mode_q, mode_d;
    logic             dbz_q, dbz_d;

    logic             w_run;
    logic [WIDTH-1:0] w_div_a;
    logic             w_take;

    assign w_run   = (state_q == S_RUN);
    // Divide: shift next dividend bit into the partial remainder before the trial subtract.
    assign w_div_a = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
    assign w_take  = hi_q[WIDTH-1] | alu_carry_i;

    always_comb begin
        alu_a_o  = '0;
        alu_b_o  = '0;
        alu_op_o = ALU_ADD;
        if (w_run) begin
            if (mode_q) begin
                alu_a_o  = w_div_a;
                alu_b_o  = opnd_q;
                alu_op_o = ALU_SUB;
            end else begin
                alu_a_o  = hi_q;
                alu_b_o  = lo_q[0] ? opnd_q : '0;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        opnd_d  = opnd_q;
        mode_d  = mode_q;
        dbz_d   = dbz_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    count_d = '0;
                    mode_d  = mode_i;
                    opnd_d  = mode_i ? opb_i : opa_i;
                    if (mode_i && (opb_i == '0)) begin
                        lo_d    = '1;
                        hi_d    = opa_i;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        lo_d    = mode_i ? opa_i : opb_i;
                        hi_d    = '0;
                        dbz_d   = 1'b0;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (mode_q) begin
                    hi_d = w_take ? alu_q_i : w_div_a;
                    lo_d = {lo_q[WIDTH-2:0], w_take};
                end else begin
                    // Product shifts right one bit per iteration; carry becomes the new MSB.
                    hi_d = {alu_carry_i, alu_q_i[WIDTH-1:1]};
                    lo_d = {alu_q_i[0], lo_q[WIDTH-1:1]};
                end
                count_d = count_q + 1'b1;
                if (count_q == LAST_ITER) begin
                    state_d = S_DONE;
                end
`ifdef MULDIV_ABORT_EN
                if (abort_i) begin
                    hi_d    = hi_q;
                    lo_d    = lo_q;
                    count_d = '0;
                    dbz_d   = 1'b0;
                    state_d = S_IDLE;
                end
`endif
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            opnd_q  <= '0;
            mode_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            opnd_q  <= opnd_d;
            mode_q  <= mode_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy_o        = w_run;
    assign done_o        = (state_q == S_DONE);
    assign result_lo_o   = lo_q;
    assign result_hi_o   = hi_q;
    assign div_by_zero_o = dbz_q;

endmodule
`default_nettype wire
